// File: rtl/stk_cmd_issuer_if.sv
// Shared stk packages and the issuer's handshake bundle.
// master drives requests/stk responses; slave is the issuer side.
package cfg_pkg;
    parameter int ENGS_N = 4;
endpackage

package stk_pkg;
    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_PEEK = 2'd2,
        OP_CLR  = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_EMPTY = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERR   = 2'd3
    } status_t;
endpackage

interface stk_cmd_issuer_if;
    import stk_pkg::*;

    logic                      i_req_vld;
    opcode_t                   i_req_opcode;
    logic [127:0]              i_req_dat;
    logic                      o_req_rdy;
    logic                      o_cmd_vld;
    opcode_t                   o_cmd_opcode;
    logic [127:0]              o_cmd_dat;
    logic                      i_cmd_ack;
    logic [cfg_pkg::ENGS_N-1:0] i_rsp_vld;
    logic [127:0]              i_rsp_dat;
    status_t                   i_rsp_status;
    logic                      o_rsp_vld;
    logic [127:0]              o_rsp_dat;
    status_t                   o_rsp_status;
    logic                      i_rsp_rdy;

    modport slave (
        input  i_req_vld, i_req_opcode, i_req_dat,
        output o_req_rdy,
        output o_cmd_vld, o_cmd_opcode, o_cmd_dat,
        input  i_cmd_ack,
        input  i_rsp_vld, i_rsp_dat, i_rsp_status,
        output o_rsp_vld, o_rsp_dat, o_rsp_status,
        input  i_rsp_rdy
    );

    modport master (
        output i_req_vld, i_req_opcode, i_req_dat,
        input  o_req_rdy,
        input  o_cmd_vld, o_cmd_opcode, o_cmd_dat,
        output i_cmd_ack,
        output i_rsp_vld, i_rsp_dat, i_rsp_status,
        input  o_rsp_vld, o_rsp_dat, o_rsp_status,
        output i_rsp_rdy
    );
endinterface

// File: rtl/stk_cmd_issuer.sv
// Per-engine stk command issuer: request FIFO, credit-gated issue, response FIFO.
// Define STK_CMD_ISSUER_TIMEOUT_EN to build the outstanding-response watchdog.
module stk_cmd_issuer
    import stk_pkg::*;
#(
    parameter int ENG_ID    = 0,
    parameter int CMDQ_N    = 4,
    parameter int OUTST_N   = 4,
    parameter int TIMEOUT_N = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    stk_cmd_issuer_if.slave              bus,
    output logic [$clog2(OUTST_N+1)-1:0] o_outst,
    output logic                         o_err_unexp_r,
    output logic                         o_timeout_r
);
    localparam int OW = $clog2(OUTST_N+1);
    localparam int CW = $clog2(CMDQ_N);
    localparam int RW = (OUTST_N > 1) ? $clog2(OUTST_N) : 1;

    typedef struct packed {
        opcode_t      op;
        logic [127:0] dat;
    } cmd_t;

    typedef struct packed {
        logic [127:0] dat;
        status_t      st;
    } rsp_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state_q, state_d;

    cmd_t          cmd_mem [CMDQ_N];
    logic [CW:0]   cq_wr, cq_rd, cq_cnt, cq_cnt_nx;
    logic          rdy_q;
    cmd_t          cq_head;

    rsp_t          rq_mem [OUTST_N];
    logic [RW:0]   rq_wr, rq_rd;
    logic [OW-1:0] rq_cnt, rq_cnt_nx, outst_nx;
    logic [OW:0]   busy_nx;
    logic          rq_empty, rq_full;
    rsp_t          rq_head;

    logic acc, fire, own, push, pop, unexp, credit_ok;
    logic unused_rsp_vld;

    // Index wraps at OUTST_N; the top bit flips on wrap to tell full from empty.
    function automatic logic [RW:0] rinc(input logic [RW:0] p);
        if (p[RW-1:0] == RW'(OUTST_N-1)) rinc = {~p[RW], {RW{1'b0}}};
        else                             rinc = p + (RW+1)'(1);
    endfunction

    assign unused_rsp_vld = ^bus.i_rsp_vld;

    assign acc   = bus.i_req_vld & rdy_q;
    assign fire  = (state_q == ISSUE) & bus.i_cmd_ack;
    assign own   = bus.i_rsp_vld[ENG_ID];
    assign push  = own & (o_outst != '0);
    assign unexp = own & (o_outst == '0);
    assign pop   = ~rq_empty & bus.i_rsp_rdy;

    assign cq_cnt    = cq_wr - cq_rd;
    assign cq_cnt_nx = cq_cnt + (CW+1)'(acc) - (CW+1)'(fire);
    assign cq_head   = cmd_mem[cq_rd[CW-1:0]];

    assign rq_empty = (rq_wr == rq_rd);
    assign rq_full  = (rq_wr[RW-1:0] == rq_rd[RW-1:0]) & (rq_wr[RW] != rq_rd[RW]);
    assign rq_head  = rq_empty ? '0 : rq_mem[rq_rd[RW-1:0]];

    always_comb begin
        rq_cnt = '0;
        if (rq_wr[RW] == rq_rd[RW])
            rq_cnt = OW'(rq_wr[RW-1:0] - rq_rd[RW-1:0]);
        else
            rq_cnt = OW'(OUTST_N) - OW'(rq_rd[RW-1:0]) + OW'(rq_wr[RW-1:0]);
    end

    // Credit looks at next-cycle totals so an ack and a response can share a cycle.
    assign outst_nx  = o_outst + OW'(fire) - OW'(push);
    assign rq_cnt_nx = rq_cnt + OW'(push) - OW'(pop);
    assign busy_nx   = {1'b0, outst_nx} + {1'b0, rq_cnt_nx};
    assign credit_ok = busy_nx < (OW+1)'(OUTST_N);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cq_cnt_nx != '0 && credit_ok) state_d = ISSUE;
            end
            ISSUE: begin
                if (fire) state_d = (cq_cnt_nx != '0 && credit_ok) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cq_wr         <= '0;
            cq_rd         <= '0;
            rq_wr         <= '0;
            rq_rd         <= '0;
            o_outst       <= '0;
            rdy_q         <= 1'b0;
            o_err_unexp_r <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc)   cq_wr <= cq_wr + (CW+1)'(1);
            if (fire)  cq_rd <= cq_rd + (CW+1)'(1);
            if (push)  rq_wr <= rinc(rq_wr);
            if (pop)   rq_rd <= rinc(rq_rd);
            o_outst <= outst_nx;
            rdy_q   <= (cq_cnt_nx != (CW+1)'(CMDQ_N));
            if (unexp) o_err_unexp_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc)  cmd_mem[cq_wr[CW-1:0]] <= '{op: bus.i_req_opcode, dat: bus.i_req_dat};
        if (push) rq_mem[rq_wr[RW-1:0]]  <= '{dat: bus.i_rsp_dat, st: bus.i_rsp_status};
    end

    assign bus.o_req_rdy    = rdy_q;
    assign bus.o_cmd_vld    = (state_q == ISSUE);
    assign bus.o_cmd_opcode = (state_q == ISSUE) ? cq_head.op : OP_PUSH;
    assign bus.o_cmd_dat    = (state_q == ISSUE) ? cq_head.dat : '0;
    assign bus.o_rsp_vld    = ~rq_empty;
    assign bus.o_rsp_dat    = rq_head.dat;
    assign bus.o_rsp_status = rq_head.st;

    rspq_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && rq_full));

`ifdef STK_CMD_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_N+1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            o_timeout_r <= 1'b0;
        end else if (push || outst_nx == '0) begin
            tmo_cnt <= '0;
        end else begin
            if (tmo_cnt != TW'(TIMEOUT_N)) tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(TIMEOUT_N-1)) o_timeout_r <= 1'b1;
        end
    end
`else
    assign o_timeout_r = 1'b0;
`endif
endmodule
